// File: rtl/mem_stage.sv
// Y86-64 memory stage: data-memory access, address-error check and the W pipeline register.
// Optional MEM_STAGE_PERF_EN adds committed read/write counters (rd_count, wr_count).
module mem_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  M_in_code,
  input  logic [63:0] M_val_e,
  input  logic [63:0] M_val_a,
  input  logic [3:0]  M_dst_e,
  input  logic [3:0]  M_dst_m,
  input  logic [1:0]  M_stat,
  input  logic        W_stall,
  output logic [63:0] m_val_m,
  output logic [1:0]  m_stat,
  output logic [1:0]  W_stat,
  output logic [3:0]  W_in_code,
  output logic [63:0] W_val_e,
  output logic [63:0] W_val_m,
  output logic [3:0]  W_dst_e,
  output logic [3:0]  W_dst_m
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);
  localparam logic [1:0]  STAT_AOK  = 2'd0;
  localparam logic [1:0]  STAT_ADR  = 2'd2;

  logic [7:0]    mem_q [MEM_BYTES];
  logic [63:0]   addr_s;
  logic [AW-1:0] idx_s;
  logic          rd_s;
  logic          wr_s;
  logic          addr_err_s;
  logic          wr_en_s;
  logic [63:0]   rdata_s;

  logic [1:0]  w_stat_d,    w_stat_q;
  logic [3:0]  w_in_code_d, w_in_code_q;
  logic [63:0] w_val_e_d,   w_val_e_q;
  logic [63:0] w_val_m_d,   w_val_m_q;
  logic [3:0]  w_dst_e_d,   w_dst_e_q;
  logic [3:0]  w_dst_m_d,   w_dst_m_q;

  always_comb begin
    addr_s = 64'd0;
    rd_s   = 1'b0;
    wr_s   = 1'b0;
    case (M_in_code)
      4'd4, 4'd8, 4'd10: begin addr_s = M_val_e; wr_s = 1'b1; end
      4'd5:              begin addr_s = M_val_e; rd_s = 1'b1; end
      4'd9, 4'd11:       begin addr_s = M_val_a; rd_s = 1'b1; end
      default:           begin addr_s = 64'd0;   rd_s = 1'b0; wr_s = 1'b0; end
    endcase
  end

  // Full 64-bit compare so huge addresses fault instead of aliasing into the array.
  assign addr_err_s = (rd_s | wr_s) & (addr_s > LAST_ADDR);
  assign idx_s      = addr_s[AW-1:0];
  assign wr_en_s    = wr_s & ~addr_err_s & (M_stat == STAT_AOK) & ~W_stall;

  always_comb begin
    rdata_s = 64'd0;
    if (rd_s && !addr_err_s) begin
      for (int i = 0; i < 8; i++) begin
        rdata_s[8*i +: 8] = mem_q[idx_s + AW'(i)];
      end
    end else begin
      rdata_s = 64'd0;
    end
  end

  assign m_val_m = rdata_s;
  assign m_stat  = addr_err_s ? STAT_ADR : M_stat;

  // The array has no reset value; reset only suppresses a write at the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (reset_n && wr_en_s) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[idx_s + AW'(i)] <= M_val_a[8*i +: 8];
      end
    end
  end

  always_comb begin
    if (W_stall) begin
      w_stat_d    = w_stat_q;
      w_in_code_d = w_in_code_q;
      w_val_e_d   = w_val_e_q;
      w_val_m_d   = w_val_m_q;
      w_dst_e_d   = w_dst_e_q;
      w_dst_m_d   = w_dst_m_q;
    end else begin
      w_stat_d    = m_stat;
      w_in_code_d = M_in_code;
      w_val_e_d   = M_val_e;
      w_val_m_d   = rdata_s;
      w_dst_e_d   = M_dst_e;
      w_dst_m_d   = M_dst_m;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_stat_q    <= STAT_AOK;
      w_in_code_q <= 4'd1;
      w_val_e_q   <= 64'd0;
      w_val_m_q   <= 64'd0;
      w_dst_e_q   <= 4'd15;
      w_dst_m_q   <= 4'd15;
    end else begin
      w_stat_q    <= w_stat_d;
      w_in_code_q <= w_in_code_d;
      w_val_e_q   <= w_val_e_d;
      w_val_m_q   <= w_val_m_d;
      w_dst_e_q   <= w_dst_e_d;
      w_dst_m_q   <= w_dst_m_d;
    end
  end

  assign W_stat    = w_stat_q;
  assign W_in_code = w_in_code_q;
  assign W_val_e   = w_val_e_q;
  assign W_val_m   = w_val_m_q;
  assign W_dst_e   = w_dst_e_q;
  assign W_dst_m   = w_dst_m_q;

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] rd_count_d, rd_count_q;
  logic [31:0] wr_count_d, wr_count_q;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_s && !addr_err_s && !W_stall) begin
      rd_count_d = rd_count_q + 32'd1;
    end else begin
      rd_count_d = rd_count_q;
    end
    if (wr_en_s) begin
      wr_count_d = wr_count_q + 32'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, load/store, address faults, stack ops, stall and counters.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  M_in_code;
  logic [63:0] M_val_e;
  logic [63:0] M_val_a;
  logic [3:0]  M_dst_e;
  logic [3:0]  M_dst_m;
  logic [1:0]  M_stat;
  logic        W_stall;
  logic [63:0] m_val_m;
  logic [1:0]  m_stat;
  logic [1:0]  W_stat;
  logic [3:0]  W_in_code;
  logic [63:0] W_val_e;
  logic [63:0] W_val_m;
  logic [3:0]  W_dst_e;
  logic [3:0]  W_dst_m;
`ifdef MEM_STAGE_PERF_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int tests = 0;
  int fails = 0;

  mem_stage #(.MEM_BYTES(1024)) dut (
    .clock(clock), .reset_n(reset_n),
    .M_in_code(M_in_code), .M_val_e(M_val_e), .M_val_a(M_val_a),
    .M_dst_e(M_dst_e), .M_dst_m(M_dst_m), .M_stat(M_stat), .W_stall(W_stall),
    .m_val_m(m_val_m), .m_stat(m_stat),
    .W_stat(W_stat), .W_in_code(W_in_code), .W_val_e(W_val_e), .W_val_m(W_val_m),
    .W_dst_e(W_dst_e), .W_dst_m(W_dst_m)
`ifdef MEM_STAGE_PERF_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm, input logic [1:0] st);
    M_in_code = ic; M_val_e = ve; M_val_a = va; M_dst_e = de; M_dst_m = dm; M_stat = st;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; W_stall = 1'b0;
    drive(4'd1, 64'd0, 64'd0, 4'd15, 4'd15, 2'd0);
    repeat (2) step();
    tests++; if (W_stat !== 2'd0) begin fails++; $display("FAIL rst_W_stat got %0d want 0", W_stat); end
    tests++; if (W_in_code !== 4'd1) begin fails++; $display("FAIL rst_W_in_code got %0d want 1", W_in_code); end
    tests++; if (W_val_e !== 64'd0 || W_val_m !== 64'd0) begin fails++; $display("FAIL rst_W_vals got %h/%h want 0/0", W_val_e, W_val_m); end
    tests++; if (W_dst_e !== 4'd15 || W_dst_m !== 4'd15) begin fails++; $display("FAIL rst_W_dst got %0d/%0d want 15/15", W_dst_e, W_dst_m); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_store_load();
    drive(4'd4, 64'h18, 64'd0, 4'd15, 4'd15, 2'd0); step();
    drive(4'd4, 64'h10, 64'h1122334455667788, 4'd15, 4'd15, 2'd0); step();
    drive(4'd5, 64'h10, 64'd0, 4'd15, 4'd3, 2'd0); #1;
    tests++; if (m_val_m !== 64'h1122334455667788) begin fails++; $display("FAIL ld_m_val_m got %h want 1122334455667788", m_val_m); end
    tests++; if (m_stat !== 2'd0) begin fails++; $display("FAIL ld_m_stat got %0d want 0", m_stat); end
    tests++; if (m_val_m[7:0] !== 8'h88) begin fails++; $display("FAIL ld_byte10 got %h want 88", m_val_m[7:0]); end
    step();
    tests++; if (W_val_m !== 64'h1122334455667788) begin fails++; $display("FAIL ld_W_val_m got %h want 1122334455667788", W_val_m); end
    tests++; if (W_dst_m !== 4'd3 || W_in_code !== 4'd5) begin fails++; $display("FAIL ld_W_dst_icode got %0d/%0d want 3/5", W_dst_m, W_in_code); end
    drive(4'd5, 64'h11, 64'd0, 4'd15, 4'd15, 2'd0); #1;
    tests++; if (m_val_m !== 64'h0011223344556677) begin fails++; $display("FAIL ld_unaligned got %h want 0011223344556677", m_val_m); end
  endtask

  task automatic test_addr_error();
    drive(4'd4, 64'd1016, 64'hDEADBEEFCAFEF00D, 4'd15, 4'd15, 2'd0); step();
    drive(4'd5, 64'd1016, 64'd0, 4'd15, 4'd15, 2'd0); #1;
    tests++; if (m_val_m !== 64'hDEADBEEFCAFEF00D || m_stat !== 2'd0) begin fails++; $display("FAIL adr_last_ok got %h/%0d want deadbeefcafef00d/0", m_val_m, m_stat); end
    drive(4'd5, 64'd1017, 64'd0, 4'd15, 4'd2, 2'd0); #1;
    tests++; if (m_stat !== 2'd2 || m_val_m !== 64'd0) begin fails++; $display("FAIL adr_rd_fault got %0d/%h want 2/0", m_stat, m_val_m); end
    step();
    tests++; if (W_stat !== 2'd2 || W_val_m !== 64'd0) begin fails++; $display("FAIL adr_W_stat got %0d/%h want 2/0", W_stat, W_val_m); end
    drive(4'd4, 64'd1017, 64'hFFFFFFFFFFFFFFFF, 4'd15, 4'd15, 2'd0); step();
    drive(4'd5, 64'd1016, 64'd0, 4'd15, 4'd15, 2'd0); #1;
    tests++; if (m_val_m !== 64'hDEADBEEFCAFEF00D) begin fails++; $display("FAIL adr_wr_blocked got %h want deadbeefcafef00d", m_val_m); end
    drive(4'd5, 64'hFFFFFFFFFFFFFFF8, 64'd0, 4'd15, 4'd15, 2'd0); #1;
    tests++; if (m_stat !== 2'd2) begin fails++; $display("FAIL adr_huge got %0d want 2", m_stat); end
    drive(4'd9, 64'd0, 64'd1017, 4'd15, 4'd15, 2'd0); #1;
    tests++; if (m_stat !== 2'd2) begin fails++; $display("FAIL adr_ret_vala got %0d want 2", m_stat); end
    drive(4'd6, 64'hFFFFFFFFFFFFFFFF, 64'd0, 4'd15, 4'd15, 2'd1); #1;
    tests++; if (m_stat !== 2'd1 || m_val_m !== 64'd0) begin fails++; $display("FAIL adr_noaccess got %0d/%h want 1/0", m_stat, m_val_m); end
  endtask

  task automatic test_stack();
    drive(4'd10, 64'h1F8, 64'hAB, 4'd4, 4'd15, 2'd0); step();
    drive(4'd11, 64'h200, 64'h1F8, 4'd4, 4'd0, 2'd0); #1;
    tests++; if (m_val_m !== 64'hAB) begin fails++; $display("FAIL pop_m_val_m got %h want ab", m_val_m); end
    step();
    tests++; if (W_val_e !== 64'h200 || W_val_m !== 64'hAB || W_dst_e !== 4'd4) begin fails++; $display("FAIL pop_W got %h/%h/%0d want 200/ab/4", W_val_e, W_val_m, W_dst_e); end
    drive(4'd8, 64'h1F0, 64'h1234, 4'd4, 4'd15, 2'd0); step();
    drive(4'd9, 64'h1F8, 64'h1F0, 4'd4, 4'd15, 2'd0); #1;
    tests++; if (m_val_m !== 64'h1234) begin fails++; $display("FAIL ret_m_val_m got %h want 1234", m_val_m); end
  endtask

  task automatic test_stall();
    drive(4'd4, 64'h20, 64'h77, 4'd15, 4'd15, 2'd0); step();
    drive(4'd6, 64'h99, 64'd0, 4'd2, 4'd15, 2'd0); step();
    W_stall = 1'b1;
    drive(4'd4, 64'h20, 64'd5, 4'd15, 4'd15, 2'd0); step();
    tests++; if (W_in_code !== 4'd6 || W_val_e !== 64'h99 || W_dst_e !== 4'd2) begin fails++; $display("FAIL stall_hold got %0d/%h/%0d want 6/99/2", W_in_code, W_val_e, W_dst_e); end
    W_stall = 1'b0;
    drive(4'd5, 64'h20, 64'd0, 4'd15, 4'd15, 2'd0); #1;
    tests++; if (m_val_m !== 64'h77) begin fails++; $display("FAIL stall_nowrite got %h want 77", m_val_m); end
    drive(4'd4, 64'h20, 64'd9, 4'd15, 4'd15, 2'd1); step();
    tests++; if (W_stat !== 2'd1) begin fails++; $display("FAIL hlt_W_stat got %0d want 1", W_stat); end
    drive(4'd5, 64'h20, 64'd0, 4'd15, 4'd15, 2'd0); #1;
    tests++; if (m_val_m !== 64'h77) begin fails++; $display("FAIL hlt_nowrite got %h want 77", m_val_m); end
  endtask

  task automatic test_reset_write();
    drive(4'd4, 64'h30, 64'h55, 4'd15, 4'd15, 2'd0); step();
    drive(4'd4, 64'h30, 64'h66, 4'd15, 4'd15, 2'd0);
    @(negedge clock); reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    drive(4'd5, 64'h30, 64'd0, 4'd15, 4'd15, 2'd0); #1;
    tests++; if (m_val_m !== 64'h55) begin fails++; $display("FAIL rst_blocks_write got %h want 55", m_val_m); end
  endtask

  task automatic test_async_reset();
    drive(4'd0, 64'h5, 64'd0, 4'd7, 4'd3, 2'd1); step();
    #2 reset_n = 1'b0;
    #1;
    tests++; if (W_stat !== 2'd0 || W_in_code !== 4'd1) begin fails++; $display("FAIL async_rst_stat_icode got %0d/%0d want 0/1", W_stat, W_in_code); end
    tests++; if (W_dst_e !== 4'd15 || W_dst_m !== 4'd15 || W_val_e !== 64'd0) begin fails++; $display("FAIL async_rst_dst got %0d/%0d/%h want 15/15/0", W_dst_e, W_dst_m, W_val_e); end
    reset_n = 1'b1;
    drive(4'd1, 64'd0, 64'd0, 4'd15, 4'd15, 2'd0);
    step();
  endtask

`ifdef MEM_STAGE_PERF_EN
  task automatic test_perf();
    tests++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin fails++; $display("FAIL perf_reset got %0d/%0d want 0/0", rd_count, wr_count); end
    drive(4'd4, 64'h40, 64'd1, 4'd15, 4'd15, 2'd0); step();
    drive(4'd8, 64'h48, 64'd2, 4'd15, 4'd15, 2'd0); step();
    drive(4'd5, 64'h40, 64'd0, 4'd15, 4'd15, 2'd0); step();
    drive(4'd9, 64'd0, 64'h48, 4'd15, 4'd15, 2'd0); step();
    drive(4'd11, 64'd0, 64'h40, 4'd15, 4'd15, 2'd0); step();
    drive(4'd5, 64'd1017, 64'd0, 4'd15, 4'd15, 2'd0); step();
    W_stall = 1'b1;
    drive(4'd5, 64'h40, 64'd0, 4'd15, 4'd15, 2'd0); step();
    drive(4'd4, 64'h40, 64'd3, 4'd15, 4'd15, 2'd0); step();
    W_stall = 1'b0;
    drive(4'd1, 64'd0, 64'd0, 4'd15, 4'd15, 2'd0); step();
    tests++; if (rd_count !== 32'd3) begin fails++; $display("FAIL perf_rd got %0d want 3", rd_count); end
    tests++; if (wr_count !== 32'd2) begin fails++; $display("FAIL perf_wr got %0d want 2", wr_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_addr_error();
    test_stack();
    test_stall();
    test_reset_write();
    test_async_reset();
`ifdef MEM_STAGE_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
